// File: rtl/act_seq_pkg.sv
// Shared definitions for the activation tile sequencer: state encoding and
// default geometry of the tile datapath.
package act_seq_pkg;

    localparam int DATA_WIDTH_DEF     = 8;
    localparam int NUM_ELEMENTS_DEF   = 16;
    localparam int ADDR_WIDTH_DEF     = 10;
    localparam int CNT_WIDTH_DEF      = 10;
    localparam int TIMEOUT_CYCLES_DEF = 15;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_READ  = 3'd1;
    localparam logic [2:0] ENC_LOAD  = 3'd2;
    localparam logic [2:0] ENC_ACT   = 3'd3;
    localparam logic [2:0] ENC_WRITE = 3'd4;
    localparam logic [2:0] ENC_ABORT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ENC_IDLE,
        S_READ  = ENC_READ,
        S_LOAD  = ENC_LOAD,
        S_ACT   = ENC_ACT,
        S_WRITE = ENC_WRITE,
        S_ABORT = ENC_ABORT
    } state_e;

    function automatic int tile_w(input int data_width, input int num_elements);
        return data_width * num_elements;
    endfunction

    localparam int TILE_W_DEF = tile_w(DATA_WIDTH_DEF, NUM_ELEMENTS_DEF);

endpackage

// File: rtl/act_seq_watchdog.sv
// Down-counter watchdog: reloaded while cleared, counts while enabled, and
// flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
module act_seq_watchdog
    import act_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = LOAD_VAL;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/act_tile_sequencer.sv
// Streams tiles from the tile buffer through the activation unit and back,
// with a watchdog that aborts the command if the unit never answers.
module act_tile_sequencer
    import act_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int NUM_ELEMENTS   = NUM_ELEMENTS_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int TILE_W        = tile_w(DATA_WIDTH, NUM_ELEMENTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_src_base,
    input  logic [ADDR_WIDTH-1:0] cmd_dst_base,
    input  logic [CNT_WIDTH-1:0]  cmd_num_tiles,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [TILE_W-1:0]     rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [TILE_W-1:0]     wr_data,
    output logic                  act_start,
    input  logic                  act_done,
    output logic [TILE_W-1:0]     act_in,
    input  logic [TILE_W-1:0]     act_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  tiles_done
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // READ  | read strobe for tile k
    // LOAD  | capture read data into act_in
    // ACT   | act_start held until act_done or watchdog expiry
    // WRITE | write result of tile k, advance or finish
    // ABORT | watchdog fired; flag error and finish
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d, tiles_done_q, tiles_done_d;
    logic [TILE_W-1:0]     act_in_q, act_in_d, result_q, result_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic rd_en_q, rd_en_d, wr_en_q, wr_en_d, act_start_q, act_start_d;
    logic busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic cmd_ready_q, cmd_ready_d;
    logic wdog_expire;

    act_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != S_ACT),
        .en     (state_q == S_ACT),
        .expire (wdog_expire)
    );

    // tiles_done doubles as the tile index k: it equals k up to the WRITE
    // edge and k+1 from then on.
    always_comb begin
        state_d      = state_q;
        src_base_d   = src_base_q;
        dst_base_d   = dst_base_q;
        num_d        = num_q;
        tiles_done_d = tiles_done_q;
        act_in_d     = act_in_q;
        result_d     = result_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        error_d      = error_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                src_base_d   = cmd_src_base;
                dst_base_d   = cmd_dst_base;
                num_d        = cmd_num_tiles;
                tiles_done_d = '0;
                error_d      = 1'b0;
                if (cmd_num_tiles == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d   = S_READ;
                    rd_addr_d = cmd_src_base;
                end
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                act_in_d = rd_data;
                state_d  = S_ACT;
            end
            // A done arriving on the expiry cycle still completes the tile.
            S_ACT: if (act_done) begin
                result_d     = act_out;
                tiles_done_d = tiles_done_q + CNT_WIDTH'(1);
                wr_addr_d    = dst_base_q + ADDR_WIDTH'(tiles_done_q);
                state_d      = S_WRITE;
            end else if (wdog_expire) begin
                state_d = S_ABORT;
            end
            S_WRITE: if (tiles_done_q == num_q) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d   = S_READ;
                rd_addr_d = src_base_q + ADDR_WIDTH'(tiles_done_q);
            end
            S_ABORT: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                error_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        rd_en_d     = (state_d == S_READ);
        wr_en_d     = (state_d == S_WRITE);
        act_start_d = (state_d == S_ACT);
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            num_q        <= '0;
            tiles_done_q <= '0;
            act_in_q     <= '0;
            result_q     <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            act_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            src_base_q   <= src_base_d;
            dst_base_q   <= dst_base_d;
            num_q        <= num_d;
            tiles_done_q <= tiles_done_d;
            act_in_q     <= act_in_d;
            result_q     <= result_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            act_start_q  <= act_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = result_q;
    assign act_start  = act_start_q;
    assign act_in     = act_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign tiles_done = tiles_done_q;

endmodule

// File: tb/tb_act_tile_sequencer.sv
// Directed bench for act_tile_sequencer with a behavioural tile buffer and a
// ReLU activation unit whose done latency can be stretched or stalled.
module tb_act_tile_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [9:0]   cmd_src_base = '0;
    logic [9:0]   cmd_dst_base = '0;
    logic [9:0]   cmd_num_tiles = '0;
    logic         rd_en, wr_en, act_start, busy, done, error;
    logic [9:0]   rd_addr, wr_addr, tiles_done;
    logic [127:0] rd_data = '0;
    logic [127:0] wr_data, act_in;
    logic [127:0] act_out = '0;
    logic         act_done = 1'b0;

    act_tile_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_base(cmd_src_base), .cmd_dst_base(cmd_dst_base),
        .cmd_num_tiles(cmd_num_tiles),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .act_start(act_start), .act_done(act_done),
        .act_in(act_in), .act_out(act_out),
        .busy(busy), .done(done), .error(error), .tiles_done(tiles_done)
    );

    always #5 clk = ~clk;

    // Tile buffer, access logs and a free-running cycle count.
    logic [127:0] mem [0:1023];
    logic         ld_en = 1'b0;
    logic [9:0]   ld_addr = '0;
    logic [127:0] ld_data = '0;
    int           cyc = 0;
    int           n_rd = 0, n_wr = 0;
    logic [9:0]   rd_log [0:63];
    logic [9:0]   wr_addr_log [0:63];
    logic [127:0] wr_data_log [0:63];
    int           wr_cyc_log [0:63];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en) mem[ld_addr] <= ld_data;
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            if (n_rd < 64) rd_log[n_rd] <= rd_addr;
            n_rd <= n_rd + 1;
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            if (n_wr < 64) begin
                wr_addr_log[n_wr] <= wr_addr;
                wr_data_log[n_wr] <= wr_data;
                wr_cyc_log[n_wr]  <= cyc;
            end
            n_wr <= n_wr + 1;
        end
    end

    // ReLU unit: done pulses act_delay cycles after act_start rises.
    int act_delay = 2;
    int act_cnt = 0;

    function automatic logic [127:0] relu(input logic [127:0] t);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[i*8 +: 8] = t[i*8+7] ? 8'h00 : t[i*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!act_start) begin
            act_cnt  <= 0;
            act_done <= 1'b0;
        end else begin
            act_cnt  <= act_cnt + 1;
            act_done <= (act_cnt == act_delay - 1);
            act_out  <= relu(act_in);
        end
    end

    // Element i is +7 where mask bit i is set, -5 elsewhere.
    function automatic logic [127:0] mk_tile(input logic [15:0] m);
        logic [127:0] t;
        for (int i = 0; i < 16; i++) t[i*8 +: 8] = m[i] ? 8'h07 : 8'hFB;
        return t;
    endfunction

    function automatic logic [127:0] exp_tile(input logic [15:0] m);
        logic [127:0] t;
        for (int i = 0; i < 16; i++) t[i*8 +: 8] = m[i] ? 8'h07 : 8'h00;
        return t;
    endfunction

    int checks = 0;
    int errors = 0;
    int t0 = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [9:0] a, input logic [127:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Called at a negedge in cycle 0; returns at the negedge of cycle 1.
    task automatic start_cmd(input logic [9:0] src, input logic [9:0] dst, input logic [9:0] n);
        cmd_valid = 1'b1; cmd_src_base = src; cmd_dst_base = dst; cmd_num_tiles = n;
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                dcyc = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    localparam logic [15:0] M0 = 16'h0000, M1 = 16'hFFFF, M2 = 16'hA5A5, M3 = 16'h0F0F;

    initial begin
        int dc, wb, rb, ta;
        bit seen_done;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_act_start", act_start, 0);
        chk("rst_tiles_done", tiles_done, 0);
        chk("rst_act_in", act_in, 0);
        chk("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        @(negedge clk);

        load_word(10'h010, mk_tile(M0));
        load_word(10'h011, mk_tile(M1));
        load_word(10'h012, mk_tile(M2));
        load_word(10'h013, mk_tile(M3));
        load_word(10'h3FE, mk_tile(M2));
        load_word(10'h3FF, mk_tile(M1));
        load_word(10'h000, mk_tile(M3));
        @(negedge clk);

        // Zero-length command
        wb = n_wr; rb = n_rd;
        start_cmd(10'h000, 10'h000, 10'd0);
        wait_done(10, dc);
        chk("zero_done_cycle", dc, 1);
        chk("zero_error", error, 0);
        chk("zero_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        chk("zero_reads", n_rd - rb, 0);
        chk("zero_writes", n_wr - wb, 0);

        // Four tiles through ReLU
        wb = n_wr; rb = n_rd;
        start_cmd(10'h010, 10'h100, 10'd4);
        chk("four_rd_en_c1", rd_en, 1);
        chk("four_rd_addr_c1", rd_addr, 10'h010);
        repeat (2) @(negedge clk);
        chk("four_act_start_c3", act_start, 1);
        chk("four_act_in_c3", act_in, mk_tile(M0));
        wait_done(60, dc);
        chk("four_done_cycle", dc, 25);
        chk("four_tiles_done", tiles_done, 4);
        chk("four_error", error, 0);
        chk("four_nwr", n_wr - wb, 4);
        chk("four_nrd", n_rd - rb, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("four_wr_addr%0d", i), wr_addr_log[wb+i], 10'h100 + 10'(i));
            chk($sformatf("four_wr_cyc%0d", i), wr_cyc_log[wb+i] - t0, 6 + 6*i);
        end
        chk("four_wr_data0", wr_data_log[wb+0], exp_tile(M0));
        chk("four_wr_data1", wr_data_log[wb+1], exp_tile(M1));
        chk("four_wr_data2", wr_data_log[wb+2], exp_tile(M2));
        chk("four_wr_data3", wr_data_log[wb+3], exp_tile(M3));

        // Address wrap with overlapping, shifted-by-one regions
        @(negedge clk);
        wb = n_wr; rb = n_rd;
        start_cmd(10'h3FE, 10'h3FF, 10'd3);
        wait_done(60, dc);
        chk("wrap_done_cycle", dc, 19);
        chk("wrap_rd0", rd_log[rb+0], 10'h3FE);
        chk("wrap_rd1", rd_log[rb+1], 10'h3FF);
        chk("wrap_rd2", rd_log[rb+2], 10'h000);
        chk("wrap_wr0", wr_addr_log[wb+0], 10'h3FF);
        chk("wrap_wr1", wr_addr_log[wb+1], 10'h000);
        chk("wrap_wr2", wr_addr_log[wb+2], 10'h001);
        // Each read sees the tile written just before it, so all equal relu(M2).
        chk("wrap_data0", wr_data_log[wb+0], exp_tile(M2));
        chk("wrap_data1", wr_data_log[wb+1], exp_tile(M2));
        chk("wrap_data2", wr_data_log[wb+2], exp_tile(M2));

        // Timeout: unit never answers
        @(negedge clk);
        act_delay = 1000;
        wb = n_wr;
        start_cmd(10'h010, 10'h300, 10'd1);
        repeat (16) @(negedge clk);
        chk("to_act_start_c17", act_start, 1);
        @(negedge clk);
        chk("to_act_start_c18", act_start, 0);
        chk("to_busy_c18", busy, 1);
        chk("to_done_c18", done, 0);
        @(negedge clk);
        chk("to_done_c19", done, 1);
        chk("to_error_c19", error, 1);
        chk("to_cmd_ready_c19", cmd_ready, 1);
        chk("to_writes", n_wr - wb, 0);

        // Done on the watchdog limit cycle wins; accept also clears error
        @(negedge clk);
        chk("to_error_sticky", error, 1);
        act_delay = 14;
        wb = n_wr;
        start_cmd(10'h011, 10'h301, 10'd1);
        chk("edge_error_cleared", error, 0);
        wait_done(40, dc);
        chk("edge_done_cycle", dc, 19);
        chk("edge_error", error, 0);
        chk("edge_nwr", n_wr - wb, 1);
        chk("edge_wr_cyc", wr_cyc_log[wb] - t0, 18);
        chk("edge_wr_data", wr_data_log[wb], exp_tile(M1));
        act_delay = 2;

        // Back-to-back, with a command attempt while busy
        @(negedge clk);
        wb = n_wr;
        start_cmd(10'h010, 10'h180, 10'd1);
        ta = t0;
        repeat (2) @(negedge clk);
        chk("b2b_ready_busy", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_src_base = 10'h012; cmd_dst_base = 10'h200; cmd_num_tiles = 10'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_done_c7", done, 1);
        chk("b2b_ready_c7", cmd_ready, 1);
        start_cmd(10'h011, 10'h181, 10'd1);
        wait_done(40, dc);
        chk("b2b_b_done_cycle", dc, 7);
        chk("b2b_nwr", n_wr - wb, 2);
        chk("b2b_wr0_addr", wr_addr_log[wb+0], 10'h180);
        chk("b2b_wr0_cyc", wr_cyc_log[wb+0] - ta, 6);
        chk("b2b_wr1_addr", wr_addr_log[wb+1], 10'h181);
        chk("b2b_wr1_cyc", wr_cyc_log[wb+1] - ta, 13);
        chk("b2b_wr1_data", wr_data_log[wb+1], exp_tile(M1));

        // Asynchronous reset during ACT of the third tile
        @(negedge clk);
        wb = n_wr;
        start_cmd(10'h010, 10'h200, 10'd4);
        repeat (15) @(negedge clk);
        chk("rstm_in_act", act_start, 1);
        rst = 1'b1;
        #1;
        chk("rstm_cmd_ready", cmd_ready, 1);
        chk("rstm_busy", busy, 0);
        chk("rstm_act_start", act_start, 0);
        chk("rstm_rd_en", rd_en, 0);
        chk("rstm_wr_en", wr_en, 0);
        chk("rstm_tiles_done", tiles_done, 0);
        chk("rstm_act_in", act_in, 0);
        chk("rstm_wr_data", wr_data, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("rstm_no_done", seen_done, 0);
        chk("rstm_writes", n_wr - wb, 2);
        chk("rstm_idle", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
